regfile_sb: RTL and testbench

Parametrised register file for the pipeline CPU. It is the successor of the current 32x32 file. It adds configurable width and depth, posedge writes with a same-cycle write-to-read bypass, and a per-register pending scoreboard for hazard detection. It also has a registered debug read port and a sequenced soft-clear engine. It sits in the ID stage: read ports feed operand fetch, the write port is driven by WB, and the issue port is driven by ID on dispatch.

---
 rtl/regfile_sb.sv | 141 ++++++++++++++
 tb/tb_regfile_sb.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file for the ID stage.
// Two combinational read ports with an optional write-to-read bypass, one WB
// write port, a per-register pending scoreboard set on dispatch, a registered
// debug read port and a sequenced soft-clear engine that wipes r1..rDEPTH-1.
module regfile_sb #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    output logic          rpend_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    output logic          rpend_b,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_addr,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done
);

    localparam int DEPTH = 1 << AW;
    localparam bit BYP   = (BYPASS != 0);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t             state_q;
    logic [AW-1:0]      clr_ptr_q;
    logic               clr_busy_q;
    logic               clr_done_q;
    logic [DW-1:0]      mem_q [DEPTH];
    logic [DEPTH-1:0]   pend_q;
    logic [DW-1:0]      dbg_data_q;

    logic wr_ok;
    logic iss_ok;
    logic byp_a;
    logic byp_b;

    // Writes and issues are frozen while the clear engine owns the array;
    // r0 is hardwired so it is never a legal target.
    always_comb begin
        wr_ok  = we && (waddr != '0) && (state_q != CLEAR);
        iss_ok = iss_valid && (iss_addr != '0) && (state_q != CLEAR);
        byp_a  = BYP && wr_ok && (waddr == raddr_a);
        byp_b  = BYP && wr_ok && (waddr == raddr_b);
    end

    // Read port A: r0 reads zero, then bypass of an accepted write, then storage.
    always_comb begin
        rdata_a = mem_q[raddr_a];
        rpend_a = pend_q[raddr_a] && !byp_a;
        if (raddr_a == '0) begin
            rdata_a = '0;
            rpend_a = 1'b0;
        end else if (byp_a) begin
            rdata_a = wdata;
        end
    end

    // Read port B: identical priority to port A.
    always_comb begin
        rdata_b = mem_q[raddr_b];
        rpend_b = pend_q[raddr_b] && !byp_b;
        if (raddr_b == '0) begin
            rdata_b = '0;
            rpend_b = 1'b0;
        end else if (byp_b) begin
            rdata_b = wdata;
        end
    end

    // Storage and scoreboard: clear engine wipes one entry per cycle;
    // otherwise a write clears pending and a same-cycle issue re-sets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            pend_q <= '0;
        end else if (state_q == CLEAR) begin
            mem_q[clr_ptr_q]  <= '0;
            pend_q[clr_ptr_q] <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem_q[waddr]  <= wdata;
                pend_q[waddr] <= 1'b0;
            end
            if (iss_ok) pend_q[iss_addr] <= 1'b1;
        end
    end

    // Debug port: one-cycle registered view of stored contents, no bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dbg_data_q <= '0;
        else     dbg_data_q <= (dbg_addr == '0) ? '0 : mem_q[dbg_addr];
    end

    // Soft-clear sequencer: walks clr_ptr 1..DEPTH-1, then a one-cycle DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            clr_ptr_q  <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            clr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q    <= CLEAR;
                        clr_ptr_q  <= AW'(1);
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_ptr_q == {AW{1'b1}}) begin
                        state_q    <= DONE;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + AW'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dbg_data = dbg_data_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing instance and a non-bypassing
// instance share all inputs so both read behaviours are checked side by side.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  raddr_a, raddr_b, waddr, iss_addr, dbg_addr;
    logic [31:0] wdata;
    logic        we, iss_valid, clr_req;

    logic [31:0] rdata_a, rdata_b, dbg_data;
    logic        rpend_a, rpend_b, clr_busy, clr_done;
    logic [31:0] n_rdata_a, n_rdata_b, n_dbg_data;
    logic        n_rpend_a, n_rpend_b, n_clr_busy, n_clr_done;

    int nvec = 0;
    int nerr = 0;

    regfile_sb #(.DW(32), .AW(5), .BYPASS(1)) dut (
        .clk(clk), .rst(rst),
        .raddr_a(raddr_a), .rdata_a(rdata_a), .rpend_a(rpend_a),
        .raddr_b(raddr_b), .rdata_b(rdata_b), .rpend_b(rpend_b),
        .we(we), .waddr(waddr), .wdata(wdata),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    regfile_sb #(.DW(32), .AW(5), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst),
        .raddr_a(raddr_a), .rdata_a(n_rdata_a), .rpend_a(n_rpend_a),
        .raddr_b(raddr_b), .rdata_b(n_rdata_b), .rpend_b(n_rpend_b),
        .we(we), .waddr(waddr), .wdata(wdata),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .dbg_addr(dbg_addr), .dbg_data(n_dbg_data),
        .clr_req(clr_req), .clr_busy(n_clr_busy), .clr_done(n_clr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we = 0; waddr = 0; wdata = 0; iss_valid = 0; iss_addr = 0; clr_req = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        raddr_a = 5'd5; raddr_b = 5'd31; dbg_addr = 5'd7;
        rst = 1;
        #12;
        nvec++;
        if ({rdata_a, rdata_b, dbg_data} !== 96'd0) begin
            nerr++; $display("FAIL reset_data: got %h %h %h exp 0", rdata_a, rdata_b, dbg_data);
        end
        nvec++;
        if ({rpend_a, rpend_b, clr_busy, clr_done} !== 4'b0) begin
            nerr++; $display("FAIL reset_flags: got %b exp 0000", {rpend_a, rpend_b, clr_busy, clr_done});
        end
        rst = 0;
        step();
    endtask

    task automatic test_write_read();
        we = 1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        idle_inputs(); raddr_a = 5'd5; raddr_b = 5'd0;
        #1;
        nvec++;
        if (rdata_a !== 32'hDEADBEEF) begin
            nerr++; $display("FAIL wr_rd_a: got %h exp deadbeef", rdata_a);
        end
        nvec++;
        if (rdata_b !== 32'h0) begin
            nerr++; $display("FAIL wr_rd_b0: got %h exp 0", rdata_b);
        end
        nvec++;
        if (n_rdata_a !== 32'hDEADBEEF) begin
            nerr++; $display("FAIL wr_rd_nb: got %h exp deadbeef", n_rdata_a);
        end
        we = 1; waddr = 5'd0; wdata = 32'h1234; raddr_a = 5'd0;
        #1;
        nvec++;
        if (rdata_a !== 32'h0) begin
            nerr++; $display("FAIL r0_bypass: got %h exp 0", rdata_a);
        end
        step();
        idle_inputs();
        #1;
        nvec++;
        if (rdata_a !== 32'h0) begin
            nerr++; $display("FAIL r0_write: got %h exp 0", rdata_a);
        end
    endtask

    task automatic test_bypass();
        we = 1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr_a = 5'd7;
        #1;
        nvec++;
        if (rdata_a !== 32'hA5A5A5A5) begin
            nerr++; $display("FAIL bypass_on: got %h exp a5a5a5a5", rdata_a);
        end
        nvec++;
        if (n_rdata_a !== 32'h0) begin
            nerr++; $display("FAIL bypass_off_same: got %h exp 0", n_rdata_a);
        end
        step();
        idle_inputs();
        #1;
        nvec++;
        if (n_rdata_a !== 32'hA5A5A5A5) begin
            nerr++; $display("FAIL bypass_off_next: got %h exp a5a5a5a5", n_rdata_a);
        end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1; iss_addr = 5'd9; raddr_a = 5'd9;
        #1;
        nvec++;
        if (rpend_a !== 1'b0) begin
            nerr++; $display("FAIL iss_same_cycle: got %b exp 0", rpend_a);
        end
        step();
        idle_inputs();
        iss_valid = 1; iss_addr = 5'd0; raddr_b = 5'd0;
        #1;
        nvec++;
        if (rpend_a !== 1'b1) begin
            nerr++; $display("FAIL iss_pending: got %b exp 1", rpend_a);
        end
        step();
        idle_inputs();
        we = 1; waddr = 5'd9; wdata = 32'h55;
        #1;
        nvec++;
        if (rpend_b !== 1'b0) begin
            nerr++; $display("FAIL iss_r0: got %b exp 0", rpend_b);
        end
        nvec++;
        if ({rpend_a, rdata_a} !== {1'b0, 32'h55}) begin
            nerr++; $display("FAIL wb_bypass_pend: got %b/%h exp 0/00000055", rpend_a, rdata_a);
        end
        nvec++;
        if ({n_rpend_a, n_rdata_a} !== {1'b1, 32'h0}) begin
            nerr++; $display("FAIL wb_nobypass_pend: got %b/%h exp 1/00000000", n_rpend_a, n_rdata_a);
        end
        step();
        idle_inputs();
        #1;
        nvec++;
        if ({rpend_a, n_rpend_a} !== 2'b00) begin
            nerr++; $display("FAIL wb_cleared: got %b exp 00", {rpend_a, n_rpend_a});
        end
        we = 1; waddr = 5'd9; wdata = 32'h66; iss_valid = 1; iss_addr = 5'd9;
        step();
        idle_inputs();
        #1;
        nvec++;
        if ({rpend_a, rdata_a} !== {1'b1, 32'h66}) begin
            nerr++; $display("FAIL set_wins: got %b/%h exp 1/00000066", rpend_a, rdata_a);
        end
    endtask

    task automatic test_debug();
        we = 1; waddr = 5'd31; wdata = 32'hCAFEF00D; dbg_addr = 5'd31;
        step();
        idle_inputs();
        nvec++;
        if (dbg_data !== 32'h0) begin
            nerr++; $display("FAIL dbg_prewrite: got %h exp 0", dbg_data);
        end
        step();
        nvec++;
        if (dbg_data !== 32'hCAFEF00D) begin
            nerr++; $display("FAIL dbg_postwrite: got %h exp cafef00d", dbg_data);
        end
        dbg_addr = 5'd5;
        step();
        nvec++;
        if (dbg_data !== 32'hDEADBEEF) begin
            nerr++; $display("FAIL dbg_r5: got %h exp deadbeef", dbg_data);
        end
        dbg_addr = 5'd0;
        step();
        nvec++;
        if (dbg_data !== 32'h0) begin
            nerr++; $display("FAIL dbg_r0: got %h exp 0", dbg_data);
        end
    endtask

    task automatic test_clear();
        int busy;
        int errs;
        for (int i = 1; i < 32; i++) begin
            we = 1; waddr = 5'(i); wdata = 32'h100 + i; iss_valid = 1; iss_addr = 5'(i);
            step();
        end
        idle_inputs();
        raddr_a = 5'd17;
        #1;
        nvec++;
        if ({rpend_a, rdata_a} !== {1'b1, 32'h111}) begin
            nerr++; $display("FAIL fill_r17: got %b/%h exp 1/00000111", rpend_a, rdata_a);
        end
        clr_req = 1;
        step();
        clr_req = 0;
        busy = 0;
        while (clr_busy && busy < 100) begin
            busy++;
            idle_inputs();
            if (busy == 5) begin
                we = 1; waddr = 5'd20; wdata = 32'hBAD; raddr_a = 5'd20;
                #1;
                nvec++;
                if ({rpend_a, rdata_a} !== {1'b1, 32'h114}) begin
                    nerr++; $display("FAIL clear_read_stored: got %b/%h exp 1/00000114", rpend_a, rdata_a);
                end
            end
            if (busy == 6) begin
                we = 1; waddr = 5'd2; wdata = 32'hBAD; iss_valid = 1; iss_addr = 5'd2;
            end
            step();
        end
        idle_inputs();
        nvec++;
        if (busy !== 31) begin
            nerr++; $display("FAIL clear_busy_len: got %0d exp 31", busy);
        end
        nvec++;
        if ({clr_done, clr_busy} !== 2'b10) begin
            nerr++; $display("FAIL clear_done_pulse: got %b exp 10", {clr_done, clr_busy});
        end
        // DONE cycle: writes accepted again, clr_req ignored.
        clr_req = 1; we = 1; waddr = 5'd4; wdata = 32'h44;
        step();
        idle_inputs();
        nvec++;
        if ({clr_done, clr_busy} !== 2'b00) begin
            nerr++; $display("FAIL clear_after_done: got %b exp 00", {clr_done, clr_busy});
        end
        errs = 0;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i); raddr_b = 5'(i);
            #1;
            if (i == 4) begin
                if ({rpend_a, rdata_a} !== {1'b0, 32'h44}) errs++;
            end else if ({rpend_a, rdata_a, rpend_b, rdata_b} !== 66'd0) begin
                errs++;
            end
        end
        nvec++;
        if (errs !== 0) begin
            nerr++; $display("FAIL clear_contents: got %0d bad entries exp 0", errs);
        end
        step();
    endtask

    task automatic test_reset_mid_clear();
        int busy;
        we = 1; waddr = 5'd20; wdata = 32'h2020; iss_valid = 1; iss_addr = 5'd20;
        step();
        idle_inputs();
        raddr_a = 5'd20;
        clr_req = 1;
        step();
        clr_req = 0;
        busy = 0;
        while (clr_busy && busy < 12) begin
            busy++;
            if (busy < 12) step();
        end
        nvec++;
        if (busy !== 12) begin
            nerr++; $display("FAIL midclr_reach: got %0d exp 12", busy);
        end
        rst = 1;
        #1;
        nvec++;
        if ({clr_busy, clr_done, rpend_a, rdata_a} !== 35'd0) begin
            nerr++; $display("FAIL midclr_reset: got %b%b%b/%h exp 000/0", clr_busy, clr_done, rpend_a, rdata_a);
        end
        @(posedge clk);
        #2;
        rst = 0;
        step();
        nvec++;
        if ({clr_busy, rdata_a} !== 33'd0) begin
            nerr++; $display("FAIL midclr_idle: got %b/%h exp 0/0", clr_busy, rdata_a);
        end
        we = 1; waddr = 5'd20; wdata = 32'h77;
        step();
        idle_inputs();
        clr_req = 1;
        step();
        clr_req = 0;
        busy = 0;
        while (clr_busy && busy < 100) begin
            busy++;
            step();
        end
        nvec++;
        if ({busy, clr_done} !== {32'd31, 1'b1}) begin
            nerr++; $display("FAIL reclear: got %0d/%b exp 31/1", busy, clr_done);
        end
        nvec++;
        if (rdata_a !== 32'h0) begin
            nerr++; $display("FAIL reclear_r20: got %h exp 0", rdata_a);
        end
    endtask

    initial begin
        raddr_a = 0; raddr_b = 0; dbg_addr = 0;
        idle_inputs();
        rst = 1;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_debug();
        test_clear();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
